// File: rtl/cordic_control_unit.sv
// Sequencing FSM for the CORDIC datapath: one full operation per accepted START.
// Optional ACK watchdog enabled by defining CORDIC_CU_WATCHDOG_EN.
module cordic_control_unit #(
  parameter int unsigned D        = 5,
  parameter int unsigned N_ITER   = 25,
  parameter int unsigned WD_LIMIT = 255
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         ACK_SUM,
  input  logic         O_F,
  input  logic         U_F,
  input  logic [D-1:0] CONT_ITERA,
  output logic         MS_1,
  output logic [1:0]   MS_2,
  output logic [1:0]   MS_3,
  output logic [1:0]   MS_4,
  output logic         ADD_SUBT,
  output logic         BEGIN_SUM,
  output logic         EN_REG1X,
  output logic         EN_REG1Y,
  output logic         EN_REG1Z,
  output logic         EN_REG2,
  output logic         EN_REG2XYZ,
  output logic         EN_REG3,
  output logic         EN_REG4,
  output logic         CLK_CDIR,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR
);

  typedef enum logic [4:0] {
    S_IDLE, S_LOAD, S_ZINIT, S_INIT_SUM, S_INIT_WAIT, S_INIT_WR, S_LUTW, S_SHIFT,
    S_CH_PREV, S_CH_SUM, S_CH_WAIT, S_CH_WR, S_NEXT, S_FIN_SUM, S_FIN_WAIT,
    S_FIN_WR, S_REWIND, S_DONE
  } state_t;

  typedef enum logic [1:0] {CH_Z = 2'd0, CH_Y = 2'd1, CH_X = 2'd2} chan_t;

  localparam logic [D-1:0] LAST_IDX = D'(N_ITER - 1);

  state_t state, state_nx;
  chan_t  chan, chan_nx;
  logic   err_nx;
  logic   waiting;
  logic   ack_ok;
  logic   wd_trip;

  assign waiting = (state == S_INIT_WAIT) || (state == S_CH_WAIT) || (state == S_FIN_WAIT);
  assign ack_ok  = waiting && ACK_SUM;

`ifdef CORDIC_CU_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                   wd_cnt <= '0;
    else if (waiting && !ACK_SUM) wd_cnt <= wd_cnt + 1'b1;
    else                       wd_cnt <= '0;
  end

  assign wd_trip = waiting && !ACK_SUM && (wd_cnt == WD_W'(WD_LIMIT - 1));
`else
  assign wd_trip = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      chan  <= CH_X;
      ERR   <= 1'b0;
    end else begin
      state <= state_nx;
      chan  <= chan_nx;
      ERR   <= err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    chan_nx    = chan;
    err_nx     = ERR;
    MS_1       = 1'b0;
    MS_2       = 2'd0;
    MS_3       = 2'd0;
    MS_4       = 2'd0;
    ADD_SUBT   = 1'b0;
    BEGIN_SUM  = 1'b0;
    EN_REG1X   = 1'b0;
    EN_REG1Y   = 1'b0;
    EN_REG1Z   = 1'b0;
    EN_REG2    = 1'b0;
    EN_REG2XYZ = 1'b0;
    EN_REG3    = 1'b0;
    EN_REG4    = 1'b0;
    CLK_CDIR   = 1'b0;
    DONE       = 1'b0;
    BUSY       = (state != S_IDLE) && (state != S_DONE);

    if (ack_ok && (O_F || U_F)) err_nx = 1'b1;

    case (state)
      S_IDLE: if (START) begin
        err_nx   = 1'b0;
        state_nx = S_LOAD;
      end
      S_LOAD: begin
        EN_REG3  = 1'b1;
        state_nx = S_ZINIT;
      end
      S_ZINIT: begin
        MS_1     = 1'b1;
        EN_REG1Z = 1'b1;
        chan_nx  = CH_X;
        state_nx = S_INIT_SUM;
      end
      S_INIT_SUM: begin
        MS_4      = 2'd2;
        ADD_SUBT  = (chan == CH_Y);
        BEGIN_SUM = 1'b1;
        state_nx  = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        MS_4     = 2'd2;
        ADD_SUBT = (chan == CH_Y);
        if (ACK_SUM) state_nx = S_INIT_WR;
      end
      S_INIT_WR: begin
        MS_4     = 2'd2;
        ADD_SUBT = (chan == CH_Y);
        if (chan == CH_X) begin
          EN_REG1X = 1'b1;
          chan_nx  = CH_Y;
          state_nx = S_INIT_SUM;
        end else begin
          EN_REG1Y = 1'b1;
          state_nx = S_LUTW;
        end
      end
      S_LUTW: state_nx = S_SHIFT;
      S_SHIFT: begin
        EN_REG2  = 1'b1;
        chan_nx  = CH_X;
        state_nx = S_CH_PREV;
      end
      S_CH_PREV: begin
        MS_2       = chan;
        MS_3       = chan;
        EN_REG2XYZ = 1'b1;
        state_nx   = S_CH_SUM;
      end
      S_CH_SUM: begin
        MS_2      = chan;
        MS_3      = chan;
        MS_4      = 2'd1;
        BEGIN_SUM = 1'b1;
        state_nx  = S_CH_WAIT;
      end
      S_CH_WAIT: begin
        MS_2 = chan;
        MS_3 = chan;
        MS_4 = 2'd1;
        if (ACK_SUM) state_nx = S_CH_WR;
      end
      S_CH_WR: begin
        MS_2 = chan;
        MS_3 = chan;
        MS_4 = 2'd1;
        case (chan)
          CH_X: begin EN_REG1X = 1'b1; chan_nx = CH_Y; state_nx = S_CH_PREV; end
          CH_Y: begin EN_REG1Y = 1'b1; chan_nx = CH_Z; state_nx = S_CH_PREV; end
          default: begin EN_REG1Z = 1'b1; state_nx = S_NEXT; end
        endcase
      end
      S_NEXT: begin
        // Counter steps on every NEXT so N_ITER == 2**D wraps to 0 with no rewind.
        CLK_CDIR = 1'b1;
        state_nx = (CONT_ITERA == LAST_IDX) ? S_FIN_SUM : S_LUTW;
      end
      S_FIN_SUM: begin
        BEGIN_SUM = 1'b1;
        state_nx  = S_FIN_WAIT;
      end
      S_FIN_WAIT: if (ACK_SUM) state_nx = S_FIN_WR;
      S_FIN_WR: begin
        EN_REG4  = 1'b1;
        state_nx = S_REWIND;
      end
      S_REWIND: begin
        if (CONT_ITERA != '0) CLK_CDIR = 1'b1;
        else                  state_nx = S_DONE;
      end
      S_DONE: begin
        DONE     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    if (wd_trip) begin
      err_nx   = 1'b1;
      state_nx = S_REWIND;
    end
  end

endmodule

// File: tb/tb_cordic_control_unit.sv
// Self-checking bench for cordic_control_unit: emulated datapath counter and adder,
// randomized operations checked against operation-level expectations.
module tb_cordic_control_unit;
  localparam int unsigned D  = 5;
  localparam int unsigned WD = 255;

  typedef struct packed {
    logic ms1; logic [1:0] ms2; logic [1:0] ms3; logic [1:0] ms4;
    logic addsub; logic bsum; logic e1x; logic e1y; logic e1z; logic e2; logic e2xyz;
    logic e3; logic e4; logic cdir; logic busy; logic done; logic err;
  } outs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, sel, ack_hold, mon_on;
  logic ack, o_f, u_f;
  int unsigned lat, flag_idx;
  bit flag_uf;
  logic [D-1:0] cont0, cont1, m_cont;
  wire outs_t o0, o1;
  outs_t m;

  int n_checks = 0, n_pass = 0;

  cordic_control_unit #(.D(D), .N_ITER(25), .WD_LIMIT(WD)) dut (
    .CLK(clk), .RST(rst), .START(start && !sel), .ACK_SUM(ack), .O_F(o_f), .U_F(u_f),
    .CONT_ITERA(cont0), .MS_1(o0.ms1), .MS_2(o0.ms2), .MS_3(o0.ms3), .MS_4(o0.ms4),
    .ADD_SUBT(o0.addsub), .BEGIN_SUM(o0.bsum), .EN_REG1X(o0.e1x), .EN_REG1Y(o0.e1y),
    .EN_REG1Z(o0.e1z), .EN_REG2(o0.e2), .EN_REG2XYZ(o0.e2xyz), .EN_REG3(o0.e3),
    .EN_REG4(o0.e4), .CLK_CDIR(o0.cdir), .BUSY(o0.busy), .DONE(o0.done), .ERR(o0.err)
  );

  cordic_control_unit #(.D(D), .N_ITER(32), .WD_LIMIT(WD)) dut32 (
    .CLK(clk), .RST(rst), .START(start && sel), .ACK_SUM(ack), .O_F(o_f), .U_F(u_f),
    .CONT_ITERA(cont1), .MS_1(o1.ms1), .MS_2(o1.ms2), .MS_3(o1.ms3), .MS_4(o1.ms4),
    .ADD_SUBT(o1.addsub), .BEGIN_SUM(o1.bsum), .EN_REG1X(o1.e1x), .EN_REG1Y(o1.e1y),
    .EN_REG1Z(o1.e1z), .EN_REG2(o1.e2), .EN_REG2XYZ(o1.e2xyz), .EN_REG3(o1.e3),
    .EN_REG4(o1.e4), .CLK_CDIR(o1.cdir), .BUSY(o1.busy), .DONE(o1.done), .ERR(o1.err)
  );

  assign m      = sel ? o1 : o0;
  assign m_cont = sel ? cont1 : cont0;

  // Datapath stand-ins: iteration counters cleared only by reset, adder ACKs lat cycles after BEGIN_SUM.
  always @(posedge clk or posedge rst) if (rst) cont0 <= '0; else if (o0.cdir) cont0 <= cont0 + 1'b1;
  always @(posedge clk or posedge rst) if (rst) cont1 <= '0; else if (o1.cdir) cont1 <= cont1 + 1'b1;

  int unsigned dly, ack_num = 0;
  always @(posedge clk or posedge rst) begin
    if (rst)                      dly <= 0;
    else if (m.bsum && !ack_hold) dly <= lat;
    else if (dly != 0)            dly <= dly - 1;
  end
  assign ack = (dly == 1);
  always @(posedge clk) if (!mon_on) ack_num <= 0; else if (ack) ack_num <= ack_num + 1;
  assign o_f = ack && !flag_uf && (ack_num + 1 == flag_idx);
  assign u_f = ack &&  flag_uf && (ack_num + 1 == flag_idx);

  int n_begin, n_cdir, n_rew, n_en4, n_done, n_busy, hold_err, cyc, en4_cyc, done_cyc;
  logic [D-1:0] cont_at_done;
  bit pending, en4_seen;
  logic [1:0] cap_ms4;
  logic cap_as;

  always @(negedge clk) begin
    if (!mon_on) begin
      n_begin = 0; n_cdir = 0; n_rew = 0; n_en4 = 0; n_done = 0; n_busy = 0; hold_err = 0;
      cyc = 0; en4_cyc = 0; done_cyc = 0; pending = 0; en4_seen = 0; cont_at_done = '1;
    end else begin
      if (m.bsum) begin
        n_begin++;
        if (pending) hold_err++;
        pending = 1; cap_ms4 = m.ms4; cap_as = m.addsub;
      end else if (pending && (m.ms4 !== cap_ms4 || m.addsub !== cap_as)) hold_err++;
      if (pending && ack) pending = 0;
      if (m.cdir) begin n_cdir++; if (en4_seen) n_rew++; end
      if (m.e4) begin n_en4++; en4_seen = 1; en4_cyc = cyc; end
      if (m.done) begin n_done++; done_cyc = cyc; cont_at_done = m_cont; end
      if (m.busy) n_busy++;
      cyc++;
    end
  end

  // Operation length from the state sequence: each add is BEGIN + lat waits + write.
  function automatic int unsigned exp_busy(int unsigned l, int unsigned n, int unsigned r);
    return 2 + 2 * (l + 2) + n * (3 + 3 * (l + 3)) + (l + 2) + r + 1;
  endfunction

  function automatic int unsigned exp_rew(int unsigned n);
    return ((1 << D) - (n % (1 << D))) % (1 << D);
  endfunction

  bit rop_timeout, err_after_start, err_at_done, err_idle;

  task automatic run_op(input int unsigned l, input int unsigned fidx, input bit fuf,
                        input int unsigned n_extra, input int unsigned limit);
    int unsigned cnt, extra;
    extra = n_extra;
    mon_on = 0; lat = l; flag_idx = fidx; flag_uf = fuf;
    @(negedge clk); mon_on = 1;
    start = 1; @(negedge clk); start = 0;
    err_after_start = m.err;
    rop_timeout = 1; cnt = 0;
    while (cnt < limit) begin
      if (m.done) begin rop_timeout = 0; err_at_done = m.err; break; end
      if (extra != 0 && m.busy && $urandom_range(0, 49) == 0) begin start = 1; extra--; end
      else start = 0;
      @(negedge clk); cnt++;
    end
    start = 0;
    @(negedge clk);
    err_idle = m.err;
  endtask

  task automatic test_reset();
    int k;
    n_checks++; if (o0 !== '0 || o1 !== '0) $display("FAIL reset_outs got %h/%h want 0", o0, o1); else n_pass++;
    rst = 0; sel = 0; lat = 3; flag_idx = 0;
    @(negedge clk); mon_on = 1; start = 1; @(negedge clk); start = 0;
    k = 0;
    while (cont0 != 7 && k < 3000) begin @(negedge clk); k++; end
    n_checks++; if (cont0 !== 5'd7) $display("FAIL reset_reach7 got %0d want 7", cont0); else n_pass++;
    @(negedge clk); @(negedge clk);
    n_checks++; if (o0.busy !== 1'b1) $display("FAIL reset_busy_before got %b want 1", o0.busy); else n_pass++;
    rst = 1; #1;
    n_checks++; if (o0 !== '0) $display("FAIL reset_mid_outs got %h want 0", o0); else n_pass++;
    n_checks++; if (cont0 !== '0) $display("FAIL reset_mid_cont got %0d want 0", cont0); else n_pass++;
    @(negedge clk); rst = 0; @(negedge clk);
    n_checks++; if (o0 !== '0) $display("FAIL reset_idle_outs got %h want 0", o0); else n_pass++;
    start = 1; @(negedge clk); start = 0;
    n_checks++; if (o0.e3 !== 1'b1 || o0.busy !== 1'b1) $display("FAIL reset_restart_load got e3=%b busy=%b want 1/1", o0.e3, o0.busy); else n_pass++;
    rst = 1; @(negedge clk); rst = 0; mon_on = 0; @(negedge clk);
  endtask

  task automatic test_nominal();
    sel = 0;
    run_op(3, 0, 0, 0, 2000);
    n_checks++; if (rop_timeout) $display("FAIL nom_timeout no DONE within 2000 cycles"); else n_pass++;
    n_checks++; if (n_begin != 2 + 3 * 25 + 1) $display("FAIL nom_begin got %0d want %0d", n_begin, 2 + 3 * 25 + 1); else n_pass++;
    n_checks++; if (n_cdir != 32) $display("FAIL nom_cdir got %0d want 32", n_cdir); else n_pass++;
    n_checks++; if (n_rew != 7) $display("FAIL nom_rewind got %0d want 7", n_rew); else n_pass++;
    n_checks++; if (n_en4 != 1 || n_done != 1) $display("FAIL nom_en4_done got %0d/%0d want 1/1", n_en4, n_done); else n_pass++;
    n_checks++; if (cont_at_done !== '0) $display("FAIL nom_cont_done got %0d want 0", cont_at_done); else n_pass++;
    n_checks++; if (n_busy != 550) $display("FAIL nom_busy got %0d want 550", n_busy); else n_pass++;
    n_checks++; if (hold_err != 0) $display("FAIL nom_hold got %0d want 0", hold_err); else n_pass++;
    n_checks++; if (err_at_done !== 1'b0) $display("FAIL nom_err got %b want 0", err_at_done); else n_pass++;
  endtask

  task automatic test_select_y();
    int cnt, k;
    bit hold_ok;
    sel = 0; mon_on = 0; lat = 3; flag_idx = 0;
    @(negedge clk); mon_on = 1; start = 1; @(negedge clk); start = 0;
    cnt = 0; k = 0;
    while (cnt < 2 && k < 200) begin @(negedge clk); k++; if (m.e2xyz) cnt++; end
    n_checks++; if (cnt != 2) $display("FAIL sel_prev_seen got %0d want 2", cnt); else n_pass++;
    n_checks++; if (m.ms2 !== 2'd1 || m.ms3 !== 2'd1) $display("FAIL sel_ms23 got %0d/%0d want 1/1", m.ms2, m.ms3); else n_pass++;
    @(negedge clk);
    n_checks++; if ({m.bsum, m.ms4, m.addsub} !== 4'b1010) $display("FAIL sel_begin got %b want 1010", {m.bsum, m.ms4, m.addsub}); else n_pass++;
    hold_ok = 1; k = 0;
    do begin
      @(negedge clk); k++;
      if (m.ms4 !== 2'd1 || m.addsub !== 1'b0 || m.e1y !== 1'b0) hold_ok = 0;
    end while (!ack && k < 20);
    n_checks++; if (!hold_ok) $display("FAIL sel_hold got unstable want stable"); else n_pass++;
    n_checks++; if (k != 3) $display("FAIL sel_ack_lat got %0d want 3", k); else n_pass++;
    @(negedge clk);
    n_checks++; if (m.e1y !== 1'b1) $display("FAIL sel_en1y got %b want 1", m.e1y); else n_pass++;
    k = 0;
    while (!m.done && k < 2000) begin @(negedge clk); k++; end
    n_checks++; if (!m.done) $display("FAIL sel_done_timeout got 0 want 1"); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_flags();
    sel = 0;
    run_op(3, 10, 0, 3, 2000);
    n_checks++; if (rop_timeout) $display("FAIL flag_timeout no DONE"); else n_pass++;
    n_checks++; if (err_at_done !== 1'b1 || err_idle !== 1'b1) $display("FAIL flag_err got %b/%b want 1/1", err_at_done, err_idle); else n_pass++;
    n_checks++; if (n_done != 1 || n_busy != 550) $display("FAIL flag_busy_start got done=%0d busy=%0d want 1/550", n_done, n_busy); else n_pass++;
    run_op(3, 0, 0, 0, 2000);
    n_checks++; if (err_after_start !== 1'b0) $display("FAIL flag_clear got %b want 0", err_after_start); else n_pass++;
    n_checks++; if (err_at_done !== 1'b0) $display("FAIL flag_clean_op got %b want 0", err_at_done); else n_pass++;
  endtask

  task automatic test_random();
    int unsigned l, fidx, ex;
    bit fuf;
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      l    = $urandom_range(1, 6);
      fidx = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 78) : 0;
      fuf  = $urandom_range(0, 1);
      ex   = $urandom_range(0, 3);
      run_op(l, fidx, fuf, ex, exp_busy(l, 25, 7) + 50);
      n_checks++; if (rop_timeout) $display("FAIL rnd%0d_timeout lat=%0d", i, l); else n_pass++;
      n_checks++; if (err_after_start !== 1'b0) $display("FAIL rnd%0d_errclr got %b want 0", i, err_after_start); else n_pass++;
      n_checks++; if (n_begin != 78 || n_cdir != 32 || n_rew != exp_rew(25))
        $display("FAIL rnd%0d_counts got begin=%0d cdir=%0d rew=%0d want 78/32/%0d", i, n_begin, n_cdir, n_rew, exp_rew(25)); else n_pass++;
      n_checks++; if (n_en4 != 1 || n_done != 1 || cont_at_done !== '0)
        $display("FAIL rnd%0d_end got en4=%0d done=%0d cont=%0d want 1/1/0", i, n_en4, n_done, cont_at_done); else n_pass++;
      n_checks++; if (n_busy != exp_busy(l, 25, 7)) $display("FAIL rnd%0d_busy got %0d want %0d", i, n_busy, exp_busy(l, 25, 7)); else n_pass++;
      n_checks++; if (err_at_done !== (fidx != 0)) $display("FAIL rnd%0d_err got %b want %b", i, err_at_done, fidx != 0); else n_pass++;
      n_checks++; if (hold_err != 0) $display("FAIL rnd%0d_hold got %0d want 0", i, hold_err); else n_pass++;
    end
  endtask

  task automatic test_niter32();
    sel = 1;
    run_op(3, 0, 0, 0, 3000);
    n_checks++; if (rop_timeout) $display("FAIL n32_timeout no DONE"); else n_pass++;
    n_checks++; if (n_rew != 0) $display("FAIL n32_rewind got %0d want 0", n_rew); else n_pass++;
    n_checks++; if (done_cyc - en4_cyc != 2) $display("FAIL n32_gap got %0d want 2", done_cyc - en4_cyc); else n_pass++;
    n_checks++; if (n_cdir != 32 || n_begin != 2 + 3 * 32 + 1) $display("FAIL n32_counts got cdir=%0d begin=%0d want 32/99", n_cdir, n_begin); else n_pass++;
    n_checks++; if (cont_at_done !== '0 || n_busy != exp_busy(3, 32, 0)) $display("FAIL n32_end got cont=%0d busy=%0d want 0/%0d", cont_at_done, n_busy, exp_busy(3, 32, 0)); else n_pass++;
    sel = 0;
  endtask

`ifdef CORDIC_CU_WATCHDOG_EN
  task automatic test_watchdog();
    sel = 0; ack_hold = 1;
    run_op(3, 0, 0, 0, WD + 33);
    ack_hold = 0;
    n_checks++; if (rop_timeout) $display("FAIL wd_timeout no DONE within %0d cycles", WD + 33); else n_pass++;
    n_checks++; if (err_at_done !== 1'b1) $display("FAIL wd_err got %b want 1", err_at_done); else n_pass++;
    n_checks++; if (n_en4 != 0 || n_begin != 1) $display("FAIL wd_path got en4=%0d begin=%0d want 0/1", n_en4, n_begin); else n_pass++;
  endtask
`endif

  initial begin
    rst = 1; start = 0; sel = 0; ack_hold = 0; mon_on = 0;
    lat = 3; flag_idx = 0; flag_uf = 0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_select_y();
    test_flags();
    test_random();
    test_niter32();
`ifdef CORDIC_CU_WATCHDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
